clock_display_ctrl: RTL and testbench

CLOCK_DISPLAY_CTRL -- requirements
Module: clock_display_ctrl

---
 rtl/clock_display_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_clock_display_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_display_ctrl.sv
// Clock display controller: 24-hour BCD time-of-day with run/set-hour/set-minute
// modes, an HH:MM or MM:SS view, and decimal-point control for colon flash and
// blinking of the field being set.
//
// Ports:
//   clk       in   system clock (rising edge)
//   rst_n     in   synchronous active-low reset
//   tick_1hz  in   one-cycle pulse per second (advances time in RUN)
//   tick_2hz  in   one-cycle pulse twice per second (blink timebase)
//   btn_mode  in   pulse: RUN -> SET_HR -> SET_MIN -> RUN
//   btn_inc   in   pulse: increment the field being set
//   btn_view  in   pulse: toggle HH:MM / MM:SS view in RUN
//   val3..0   out  BCD digits, val3 leftmost
//   dot3..0   out  decimal point requests
//   mode      out  0 = RUN, 1 = SET_HR, 2 = SET_MIN
module clock_display_ctrl #(
  parameter int unsigned BLINK = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_view,
  output logic [3:0] val3,
  output logic [3:0] val2,
  output logic [3:0] val1,
  output logic [3:0] val0,
  output logic       dot3,
  output logic       dot2,
  output logic       dot1,
  output logic       dot0,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  // Two-digit BCD increment modulo 60; result = {wrapped, tens, units}.
  function automatic logic [8:0] inc60(input logic [3:0] t, input logic [3:0] u);
    logic [8:0] r;
    if (u != 4'd9)      r = {1'b0, t, u + 4'd1};
    else if (t != 4'd5) r = {1'b0, t + 4'd1, 4'd0};
    else                r = {1'b1, 4'd0, 4'd0};
    return r;
  endfunction

  // Two-digit BCD increment modulo 24; result = {tens, units}.
  function automatic logic [7:0] inc24(input logic [3:0] t, input logic [3:0] u);
    logic [7:0] r;
    if (t == 4'd2 && u == 4'd3) r = 8'h00;
    else if (u == 4'd9)         r = {t + 4'd1, 4'd0};
    else                        r = {t, u + 4'd1};
    return r;
  endfunction

  state_t     r_state;
  logic [3:0] r_hr_t, r_hr_u, r_min_t, r_min_u, r_sec_t, r_sec_u;
  logic       r_view;
  logic       r_blink;
  logic [15:0] r_val;
  logic [3:0]  r_dot;
  logic [1:0]  r_mode;

  state_t     w_state_nxt;
  logic [3:0] w_hr_t_nxt, w_hr_u_nxt, w_min_t_nxt, w_min_u_nxt, w_sec_t_nxt, w_sec_u_nxt;
  logic       w_view_nxt;
  logic       w_blink_nxt;
  logic [8:0] w_sec_inc;
  logic [8:0] w_min_inc;
  logic [7:0] w_hr_inc;
  logic       w_show_mmss;
  logic       w_set_dot;
  logic [15:0] w_val;
  logic [3:0]  w_dot;

  assign w_sec_inc = inc60(r_sec_t, r_sec_u);
  assign w_min_inc = inc60(r_min_t, r_min_u);
  assign w_hr_inc  = inc24(r_hr_t, r_hr_u);

  // Next-state and next-time logic; btn_mode always wins over btn_inc.
  always_comb begin
    w_state_nxt = r_state;
    w_hr_t_nxt  = r_hr_t;
    w_hr_u_nxt  = r_hr_u;
    w_min_t_nxt = r_min_t;
    w_min_u_nxt = r_min_u;
    w_sec_t_nxt = r_sec_t;
    w_sec_u_nxt = r_sec_u;
    w_view_nxt  = r_view;
    w_blink_nxt = 1'b0;  // cleared in RUN and on any entry into a set mode
    case (r_state)
      ST_RUN: begin
        if (tick_1hz) begin
          {w_sec_t_nxt, w_sec_u_nxt} = w_sec_inc[7:0];
          if (w_sec_inc[8]) begin
            {w_min_t_nxt, w_min_u_nxt} = w_min_inc[7:0];
            if (w_min_inc[8]) {w_hr_t_nxt, w_hr_u_nxt} = w_hr_inc;
          end
        end
        if (btn_view) w_view_nxt = ~r_view;
        if (btn_mode) w_state_nxt = ST_SET_HR;
      end
      ST_SET_HR: begin
        if (btn_mode) begin
          w_state_nxt = ST_SET_MIN;
        end else begin
          if (btn_inc) {w_hr_t_nxt, w_hr_u_nxt} = w_hr_inc;
          w_blink_nxt = r_blink ^ tick_2hz;
        end
      end
      ST_SET_MIN: begin
        if (btn_mode) begin
          w_state_nxt = ST_RUN;
          w_sec_t_nxt = 4'd0;
          w_sec_u_nxt = 4'd0;
        end else begin
          if (btn_inc) {w_min_t_nxt, w_min_u_nxt} = w_min_inc[7:0];
          w_blink_nxt = r_blink ^ tick_2hz;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Display mapping from current internal state; set modes force HH:MM.
  always_comb begin
    w_show_mmss = (r_state == ST_RUN) && r_view;
    w_set_dot   = (BLINK != 0) ? ~r_blink : 1'b1;
    w_val       = w_show_mmss ? {r_min_t, r_min_u, r_sec_t, r_sec_u}
                              : {r_hr_t, r_hr_u, r_min_t, r_min_u};
    w_dot       = 4'b0000;
    case (r_state)
      ST_RUN:     w_dot = {1'b0, ~r_sec_u[0], 2'b00};
      ST_SET_HR:  w_dot = {w_set_dot, w_set_dot, 2'b00};
      ST_SET_MIN: w_dot = {2'b00, w_set_dot, w_set_dot};
      default:    w_dot = 4'b0000;
    endcase
  end

  // State register: FSM state, time, view, blink and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_hr_t  <= 4'd0;
      r_hr_u  <= 4'd0;
      r_min_t <= 4'd0;
      r_min_u <= 4'd0;
      r_sec_t <= 4'd0;
      r_sec_u <= 4'd0;
      r_view  <= 1'b0;
      r_blink <= 1'b0;
      r_val   <= 16'h0000;
      r_dot   <= 4'b0000;
      r_mode  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_hr_t  <= w_hr_t_nxt;
      r_hr_u  <= w_hr_u_nxt;
      r_min_t <= w_min_t_nxt;
      r_min_u <= w_min_u_nxt;
      r_sec_t <= w_sec_t_nxt;
      r_sec_u <= w_sec_u_nxt;
      r_view  <= w_view_nxt;
      r_blink <= w_blink_nxt;
      r_val   <= w_val;
      r_dot   <= w_dot;
      r_mode  <= r_state;
    end
  end

  assign {val3, val2, val1, val0} = r_val;
  assign {dot3, dot2, dot1, dot0} = r_dot;
  assign mode = r_mode;

endmodule

// File: tb/tb_clock_display_ctrl.sv
// Testbench for clock_display_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a seconds-of-day reference model.
module tb_clock_display_ctrl;

  localparam int unsigned BLINK = 1;

  logic clk = 1'b0;
  logic rst_n, tick_1hz, tick_2hz, btn_mode, btn_inc, btn_view;
  logic [3:0] val3, val2, val1, val0;
  logic dot3, dot2, dot1, dot0;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_t;      // seconds since midnight
  int m_mode;   // 0 RUN, 1 SET_HR, 2 SET_MIN
  bit m_view;
  bit m_blink;

  logic [15:0] e_val;
  logic [3:0]  e_dot;
  logic [1:0]  e_mode;

  always #5 clk = ~clk;

  clock_display_ctrl #(.BLINK(BLINK)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_view(btn_view),
    .val3(val3), .val2(val2), .val1(val1), .val0(val0),
    .dot3(dot3), .dot2(dot2), .dot1(dot1), .dot0(dot0),
    .mode(mode)
  );

  function automatic logic [3:0] d4(input int x);
    return 4'(x);
  endfunction

  // Expected outputs for the current model state.
  task automatic model_disp();
    int h, m, s;
    bit sd;
    h = m_t / 3600;
    m = (m_t / 60) % 60;
    s = m_t % 60;
    if (m_mode == 0 && m_view)
      e_val = {d4(m / 10), d4(m % 10), d4(s / 10), d4(s % 10)};
    else
      e_val = {d4(h / 10), d4(h % 10), d4(m / 10), d4(m % 10)};
    sd = (BLINK != 0) ? !m_blink : 1'b1;
    case (m_mode)
      0:       e_dot = {1'b0, ((s % 10) % 2) == 0, 2'b00};
      1:       e_dot = {sd, sd, 2'b00};
      default: e_dot = {2'b00, sd, sd};
    endcase
    e_mode = 2'(m_mode);
  endtask

  task automatic model_step(input bit t1, input bit t2, input bit bm, input bit bi, input bit bv);
    int h, m;
    case (m_mode)
      0: begin
        if (t1) m_t = (m_t + 1) % 86400;
        if (bv) m_view = !m_view;
        if (bm) begin m_mode = 1; m_blink = 0; end
      end
      1: begin
        if (bm) begin
          m_mode = 2; m_blink = 0;
        end else begin
          if (bi) begin
            h = m_t / 3600;
            m_t = ((h + 1) % 24) * 3600 + m_t % 3600;
          end
          if (t2) m_blink = !m_blink;
        end
      end
      default: begin
        if (bm) begin
          m_mode = 0; m_blink = 0;
          m_t = m_t - (m_t % 60);
        end else begin
          if (bi) begin
            m = (m_t / 60) % 60;
            m_t = m_t - m * 60 + ((m + 1) % 60) * 60;
          end
          if (t2) m_blink = !m_blink;
        end
      end
    endcase
  endtask

  // One clock cycle: drive inputs, advance model, compare outputs after the edge.
  task automatic cyc(input bit rn, input bit t1, input bit t2, input bit bm, input bit bi, input bit bv);
    rst_n = rn; tick_1hz = t1; tick_2hz = t2; btn_mode = bm; btn_inc = bi; btn_view = bv;
    if (!rn) begin
      e_val = 16'h0000; e_dot = 4'b0000; e_mode = 2'd0;
      m_t = 0; m_mode = 0; m_view = 0; m_blink = 0;
    end else begin
      model_disp();
      model_step(t1, t2, bm, bi, bv);
    end
    @(posedge clk);
    #1;
    checks++;
    assert ({val3, val2, val1, val0} === e_val) else begin
      errors++;
      $error("FAIL val t=%0t observed %h expected %h", $time, {val3, val2, val1, val0}, e_val);
    end
    checks++;
    assert ({dot3, dot2, dot1, dot0} === e_dot) else begin
      errors++;
      $error("FAIL dot t=%0t observed %b expected %b", $time, {dot3, dot2, dot1, dot0}, e_dot);
    end
    checks++;
    assert (mode === e_mode) else begin
      errors++;
      $error("FAIL mode t=%0t observed %0d expected %0d", $time, mode, e_mode);
    end
    tick_1hz = 0; tick_2hz = 0; btn_mode = 0; btn_inc = 0; btn_view = 0;
  endtask

  task automatic idle(); cyc(1, 0, 0, 0, 0, 0); endtask
  task automatic press_mode(); cyc(1, 0, 0, 1, 0, 0); endtask
  task automatic press_inc(); cyc(1, 0, 0, 0, 1, 0); endtask
  task automatic tick(); cyc(1, 1, 0, 0, 0, 0); endtask

  // Scenario check of a DUT output against a fixed value from the scenario.
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // From RUN, enter SET_MIN with time h:m (seconds untouched).
  task automatic go_set(input int h, input int m);
    int nh, nm;
    press_mode();
    nh = (h - m_t / 3600 + 24) % 24;
    for (int i = 0; i < nh; i++) press_inc();
    press_mode();
    nm = (m - (m_t / 60) % 60 + 60) % 60;
    for (int i = 0; i < nm; i++) press_inc();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    go_set(h, m);
    press_mode();
    for (int i = 0; i < s; i++) tick();
  endtask

  initial begin
    rst_n = 0; tick_1hz = 0; tick_2hz = 0; btn_mode = 0; btn_inc = 0; btn_view = 0;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 1, 1);
    chk("reset_val", {val3, val2, val1, val0}, 16'h0000);
    idle();
    chk("run_colon", {12'h000, dot3, dot2, dot1, dot0}, 16'h0004);

    // Hour set with wrap, ticks frozen
    press_mode();
    for (int i = 0; i < 25; i++) press_inc();
    for (int i = 0; i < 3; i++) tick();
    idle();
    chk("hr_wrap", {val3, val2, val1, val0}, 16'h0100);
    chk("hr_mode", {14'h0, mode}, 16'h0001);
    press_mode();
    press_mode();

    // Minute set and exit
    go_set(12, 58);
    for (int i = 0; i < 3; i++) press_inc();
    press_mode();
    idle();
    chk("min_exit_val", {val3, val2, val1, val0}, 16'h1201);
    chk("min_exit_mode", {14'h0, mode}, 16'h0000);

    // Simultaneous events
    for (int i = 0; i < 7; i++) tick();
    press_mode();
    cyc(1, 0, 0, 1, 1, 0);
    idle();
    chk("mode_inc_mode", {14'h0, mode}, 16'h0002);
    chk("mode_inc_hr", {8'h00, val3, val2}, 16'h0012);
    cyc(1, 1, 0, 1, 0, 0);
    btn_view = 0;
    cyc(1, 0, 0, 0, 0, 1);
    idle();
    chk("tick_exit_mmss", {val3, val2, val1, val0}, 16'h0100);
    cyc(1, 0, 0, 0, 0, 1);

    // Tick and mode together in RUN
    cyc(1, 1, 0, 1, 0, 0);
    press_mode();
    press_mode();

    // Full rollover
    set_time(23, 59, 59);
    idle();
    chk("pre_roll", {val3, val2, val1, val0}, 16'h2359);
    tick();
    idle();
    chk("rollover", {val3, val2, val1, val0}, 16'h0000);

    // View and blink
    set_time(10, 7, 42);
    cyc(1, 0, 0, 0, 0, 1);
    idle();
    chk("view_mmss", {val3, val2, val1, val0}, 16'h0742);
    press_mode();
    idle();
    chk("set_forces_hhmm", {val3, val2, val1, val0}, 16'h1007);
    chk("blink_start", {12'h000, dot3, dot2, dot1, dot0}, 16'h000c);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 1, 0, 0, 0);
      idle();
    end
    press_mode();
    press_mode();
    idle();
    chk("view_restored", {val3, val2, val1, val0}, 16'h0700);

    // Reset mid-edit
    cyc(1, 0, 0, 0, 0, 1);
    go_set(5, 30);
    idle();
    chk("pre_reset", {val3, val2, val1, val0}, 16'h0530);
    cyc(0, 1, 1, 1, 1, 1);
    chk("reset_edit_val", {val3, val2, val1, val0}, 16'h0000);
    chk("reset_edit_dot", {12'h000, dot3, dot2, dot1, dot0}, 16'h0000);
    chk("reset_edit_mode", {14'h0, mode}, 16'h0000);
    idle();

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
